// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush, programmable bubble value.
// Define PIPE_STAGE_SKID_EN to add a skid entry that makes in_ready a flop output.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic             main_valid;
  logic             main_valid_n;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] main_data_n;
  logic             accept;
  logic             emit;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic             skid_valid;
  logic             skid_valid_n;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_data_n;
  logic             rdy_q;
  logic             rdy_n;

  // Registered ready: high whenever the skid slot is free; flush still squashes it.
  assign in_ready = rdy_q & ~flush & ~clr;
  assign count    = 2'(main_valid) + 2'(skid_valid);

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_data_n  = RESET_VAL;
      skid_valid_n = 1'b0;
      skid_data_n  = RESET_VAL;
    end else if (emit && skid_valid) begin
      // Oldest waiting beat advances; any new beat takes the freed slot.
      main_valid_n = 1'b1;
      main_data_n  = skid_data;
      skid_valid_n = accept;
      if (accept) begin
        skid_data_n = in_data;
      end
    end else if (emit) begin
      if (accept) begin
        main_data_n = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept && main_valid) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end else if (accept) begin
      main_valid_n = 1'b1;
      main_data_n  = in_data;
    end
    rdy_n = ~skid_valid_n;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
      rdy_q      <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      rdy_q      <= rdy_n;
    end
  end

`else

  // Single entry: a beat is taken when empty or when the held beat leaves this cycle.
  assign in_ready = ~clr & ~flush & (~main_valid | out_ready);
  assign count    = 2'(main_valid);

  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    if (flush) begin
      main_valid_n = 1'b0;
      main_data_n  = RESET_VAL;
    end else if (accept) begin
      main_valid_n = 1'b1;
      main_data_n  = in_data;
    end else if (emit) begin
      main_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_valid <= 1'b0;
      main_data  <= RESET_VAL;
    end else begin
      main_valid <= main_valid_n;
      main_data  <= main_data_n;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised-ready bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN when defined.
module tb_pipe_stage_reg;

  localparam int unsigned   W    = 32;
  localparam logic [W-1:0]  RV   = 32'h13;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          q[$];
    logic [31:0] seq;
    logic [31:0] exp;
    logic        acc;
    logic        em;

    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state while clr is high
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, RV);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    clr = 1'b0;
    #1;
    chk("rel_ready_pre_edge", 32'(in_ready), SKID ? 32'd0 : 32'd1);
    step();
    chk("rel_ready_post_edge", 32'(in_ready), 32'd1);

    // Streaming 1..4 back to back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      step();
      chk("stream_data", out_data, 32'(i));
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 32'(out_valid), 32'd0);
    chk("stream_hold_data", out_data, 32'd4);

    // Stall with A5 held while B6 is offered
    in_valid = 1'b1; in_data = 32'hA5;
    step();
    out_ready = 1'b0; in_data = 32'hB6;
    #1;
    chk("stall_ready_first", 32'(in_ready), SKID ? 32'd1 : 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", out_data, 32'hA5);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_count", 32'(count), SKID ? 32'd2 : 32'd1);
`ifdef PIPE_STAGE_SKID_EN
      in_valid = 1'b0;
`endif
    end
    out_ready = 1'b1;
    step();
    chk("release_data", out_data, 32'hB6);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_count", 32'(count), 32'd1);
    in_valid = 1'b0;
    step();
    chk("release_drain_valid", 32'(out_valid), 32'd0);
    chk("release_drain_count", 32'(count), 32'd0);
    chk("release_hold_data", out_data, 32'hB6);

    // Flush drops the held beat and the concurrent input beat
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h7;
    step();
    chk("pre_flush_data", out_data, 32'h7);
    flush = 1'b1; in_data = 32'h8;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", out_data, RV);
    chk("flush_count", 32'(count), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_no_ghost", 32'(out_valid), 32'd0);

    // Flush under stall with both entries full, then resume
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h21;
    step();
    in_data = 32'h22;
    step();
    chk("full_count", 32'(count), SKID ? 32'd2 : 32'd1);
    in_valid = 1'b0; flush = 1'b1;
    step();
    chk("full_flush_valid", 32'(out_valid), 32'd0);
    chk("full_flush_count", 32'(count), 32'd0);
    chk("full_flush_data", out_data, RV);
    flush = 1'b0; in_valid = 1'b1; in_data = 32'h33; out_ready = 1'b1;
    step();
    chk("resume_data", out_data, 32'h33);
    chk("resume_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("resume_drain_valid", 32'(out_valid), 32'd0);

    // Random backpressure: output order must equal input order
    seq = 32'd100;
    for (int c = 0; c < 2000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = seq;
        seq      = seq + 32'd1;
      end
      #1;
      acc = in_valid & in_ready;
      em  = out_valid & out_ready;
      if (em) begin
        exp = (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF;
        chk("rand_order", out_data, exp);
      end
      if (acc) q.push_back(int'(in_data));
      step();
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        exp = (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD_BEEF;
        chk("drain_order", out_data, exp);
      end
      step();
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);

    // Asynchronous clear mid-cycle while a beat is held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    step();
    chk("pre_clr_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    clr = 1'b1;
    #1;
    chk("clr_async_valid", 32'(out_valid), 32'd0);
    chk("clr_async_data", out_data, RV);
    chk("clr_async_count", 32'(count), 32'd0);
    chk("clr_async_ready", 32'(in_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
